occupancy_counter: RTL and testbench
====================================

# occupancy_counter

Produces the 4-bit count that drives the `counter` input of the seven-segment controller. Two raw push-button inputs are synchronised and debounced, then edge-detected. Each accepted press increments or decrements a saturating count between 0 and `MAX_COUNT`. Full and empty flags are also exported for LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a level change (10 ms at 100 MHz). Legal range ≥ 2.
- `MAX_COUNT`, default 9: upper saturation value. Legal range 1..15.
- `clk`  in  1  system clock; the single clock of the block.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `btn_inc`  in  1  raw, asynchronous, bouncy increment button (high = pressed).
- `btn_dec`  in  1  raw, asynchronous, bouncy decrement button (high = pressed).
- `counter`  out  4  current count, registered; feeds the seven-segment controller.
- `full`  out  1  registered; high when `counter == MAX_COUNT`.
- `empty`  out  1  registered; high when `counter == 0`.

## Operation
- Each button path has the same stages:
  - 2-flop synchroniser, giving `s`.
  - Debounce counter `dcnt`, `$clog2(DEBOUNCE_CYCLES)` bits, plus a registered `stable` level.
  - Rising-edge detector producing a registered one-cycle `press` pulse.
- Debounce rule, evaluated each edge:
  - If `s == stable`, then `dcnt <= 0`.
  - Otherwise `dcnt` increments.
  - When `s != stable` and `dcnt == DEBOUNCE_CYCLES-1`, then `stable <= s` and `dcnt <= 0`.
  - Any mismatch run shorter than `DEBOUNCE_CYCLES` samples is discarded.
- `press <= stable & ~stable_q`, with `stable_q` a one-cycle delay of `stable`. Release produces no pulse.
- Count update, on the edge after `press` is high:
  - `inc_press` only, and `counter < MAX_COUNT`: `counter + 1`.
  - `dec_press` only, and `counter > 0`: `counter - 1`.
  - `inc_press` and `dec_press` in the same cycle: no change.
  - Increment at `MAX_COUNT`, or decrement at 0: no change (saturate, never wrap).
- `full` and `empty` are registered from the next-state count, so they change on the same edge as `counter`.
- Holding a button gives exactly one step. A new step requires a debounced release followed by a debounced press.

## Timing
- Reset values: `counter = 0`, `empty = 1`, `full = 0`. Synchroniser flops, `stable`, `stable_q`, `press` and `dcnt` all reset to 0.
- Latency: let edge 1 be the first edge that samples the button high, with the input held thereafter.
  - `stable` rises at edge `DEBOUNCE_CYCLES+2`.
  - `press` is high for the cycle after edge `DEBOUNCE_CYCLES+3`.
  - `counter` updates at edge `DEBOUNCE_CYCLES+4`.
- Minimum accepted press or release width: `DEBOUNCE_CYCLES` cycles after synchronisation.
- Reset mid-debounce or mid-press: all state clears immediately.
  - A button still held at reset release produces one step after the full latency. `stable` restarts at 0, so this is treated as a new press.
- Inc and dec presses whose pulses fall in different cycles are applied in order, one step each.

## Structure
- Shared package `counter_pkg`:
  - `COUNT_W = 4`.
  - Default `MAX_COUNT = 9`.
  - Default `DEBOUNCE_CYCLES`.
  - `count_t` typedef for the 4-bit count, shared with the seven-segment controller's input.
- Sub-module `button_debouncer`:
  - Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `press`.
  - Contains the synchroniser, debounce counter and edge detector.
  - Instantiated twice. The top level holds only the saturating counter and flags.

## Test plan
Benches run with `DEBOUNCE_CYCLES = 4` and `MAX_COUNT = 9`.
- Reset then idle 20 cycles → `counter = 0`, `empty = 1`, `full = 0`, unchanged throughout.
- Clean `btn_inc` press held 20 cycles, asserted before edge 1 → `counter` becomes 1 exactly at edge 8. `empty` falls on that same edge. No further change while held.
- Bouncy `btn_inc`: 1-, 2- and 3-cycle high glitches separated by lows, then a steady high → only the steady high counts, giving `counter = 1`. A lone 3-cycle glitch gives no change.
- Ten debounced `btn_inc` presses → `counter` steps 1..9. `full = 1` after the ninth press. The tenth press leaves `counter = 9`.
- At `counter = 0`, a debounced `btn_dec` press → `counter` stays 0 and `empty` stays 1. Then, at `counter = 5`, `btn_inc` and `btn_dec` pressed on the same cycle → pulses coincide and `counter` stays 5.
- `rst` asserted two cycles into the debounce of a held `btn_inc` (at `counter = 3`) → `counter = 0` asynchronously. After `rst` is released with the button still held, exactly one step occurs, giving `counter = 1`.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared count type and defaults for the occupancy counter
package counter_pkg;

    localparam int unsigned COUNT_W                 = 4;
    localparam int unsigned MAX_COUNT_DEFAULT       = 9;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Count value; the seven-segment controller takes its input in the same type
    typedef logic [COUNT_W-1:0] count_t;

endpackage : counter_pkg

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser, debounce filter and press-edge detector
module button_debouncer
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic             press_q;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples;
    // any agreeing sample restarts the run
    always_comb begin
        dcnt_d   = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (dcnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state plus a one-cycle delayed copy of the filtered level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q       <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            dcnt_q       <= dcnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign press = press_q;

endmodule : button_debouncer

// File: rtl/occupancy_counter.sv
// rtl/occupancy_counter.sv - saturating up/down count driven by two debounced buttons
module occupancy_counter
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned MAX_COUNT       = MAX_COUNT_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   btn_inc,
    input  logic   btn_dec,
    output count_t counter,
    output logic   full,
    output logic   empty
);

    localparam count_t MAX_C = count_t'(MAX_COUNT);

    logic   inc_press;
    logic   dec_press;
    count_t count_q;
    count_t count_d;
    logic   full_q;
    logic   empty_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_inc_debouncer (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_inc),
        .press   (inc_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dec_debouncer (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dec),
        .press   (dec_press)
    );

    // Single-step saturating update; simultaneous presses cancel out
    always_comb begin
        count_d = count_q;
        case ({inc_press, dec_press})
            2'b10: if (count_q < MAX_C) count_d = count_q + count_t'(1);
            2'b01: if (count_q != '0)   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags come from the next-state count so they move on the same edge as the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == MAX_C);
            empty_q <= (count_d == '0);
        end
    end

    assign counter = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule : occupancy_counter

// File: tb/tb_occupancy_counter.sv
// tb/tb_occupancy_counter.sv - directed self-checking bench for occupancy_counter
module tb_occupancy_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] counter;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    occupancy_counter #(
        .DEBOUNCE_CYCLES (4),
        .MAX_COUNT       (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .counter (counter),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input int f, input int e);
        chk({tag, "_counter"}, int'(counter), c);
        chk({tag, "_full"},    int'(full),    f);
        chk({tag, "_empty"},   int'(empty),   e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Press held 10 cycles (count moves at edge 8), then released 10 cycles to re-arm
    task automatic press_btn(input logic inc, input logic dec);
        btn_inc = inc;
        btn_dec = dec;
        step(10);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        step(10);
    endtask

    initial begin
        rst     = 1'b1;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        step(3);
        chk_state("reset", 0, 0, 1);
        rst = 1'b0;

        // Idle: nothing moves
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk_state("idle", 0, 0, 1);
        end

        // Clean press: count changes exactly at edge 8
        btn_inc = 1'b1;
        step(7);
        chk_state("clean_e7", 0, 0, 1);
        step(1);
        chk_state("clean_e8", 1, 0, 0);
        step(12);
        chk_state("clean_held", 1, 0, 0);
        btn_inc = 1'b0;
        step(10);
        chk_state("clean_release", 1, 0, 0);

        // Bouncy press: 1/2/3-cycle glitches rejected, the steady high counts once
        do_reset();
        btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(2);
        btn_inc = 1'b1; step(2); btn_inc = 1'b0; step(2);
        btn_inc = 1'b1; step(3); btn_inc = 1'b0; step(2);
        chk_state("bounce_glitches", 0, 0, 1);
        btn_inc = 1'b1;
        step(12);
        chk_state("bounce_steady", 1, 0, 0);
        btn_inc = 1'b0;
        step(10);
        btn_inc = 1'b1; step(3); btn_inc = 1'b0; step(10);
        chk_state("lone_glitch", 1, 0, 0);

        // Ten presses saturate at 9
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            press_btn(1'b1, 1'b0);
            chk_state($sformatf("inc_%0d", i), (i > 9) ? 9 : i, (i >= 9) ? 1 : 0, 0);
        end

        // Decrement at zero saturates
        do_reset();
        press_btn(1'b0, 1'b1);
        chk_state("dec_at_zero", 0, 0, 1);

        // Simultaneous presses at 5 cancel
        for (int i = 0; i < 5; i++) press_btn(1'b1, 1'b0);
        chk_state("reach_5", 5, 0, 0);
        press_btn(1'b1, 1'b1);
        chk_state("both_at_5", 5, 0, 0);
        press_btn(1'b0, 1'b1);
        chk_state("dec_from_5", 4, 0, 0);

        // Reset in the middle of a held press's debounce
        do_reset();
        for (int i = 0; i < 3; i++) press_btn(1'b1, 1'b0);
        chk_state("reach_3", 3, 0, 0);
        btn_inc = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 1);
        step(1);
        rst = 1'b0;
        step(7);
        chk_state("post_rst_e7", 0, 0, 1);
        step(1);
        chk_state("post_rst_e8", 1, 0, 0);
        step(10);
        chk_state("post_rst_held", 1, 0, 0);
        btn_inc = 1'b0;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_occupancy_counter
